// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared defaults, FSM states and constants for the MAC accumulate stage
package mac_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;

    localparam logic [DEF_ACC_W-1:0] ACC_MAX = {DEF_ACC_W{1'b1}};

    // Partial-frame state: IDLE means no terms of the current frame have been taken yet
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

// File: rtl/cla_8bit.sv
// rtl/cla_8bit.sv - 8-bit carry-lookahead adder slice with carry in/out
module cla_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       run_p;

    // Every carry is an independent sum-of-products of generate/propagate terms
    always_comb begin
        g     = a & b;
        p     = a ^ b;
        c     = '0;
        c[0]  = cin;
        run_p = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_p    = 1'b1;
            c[i + 1] = 1'b0;
            for (int j = i; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (g[j] & run_p);
                run_p    = run_p & p[j];
            end
            c[i + 1] = c[i + 1] | (run_p & cin);
        end
        s    = p ^ c[7:0];
        cout = c[8];
    end

endmodule

// File: rtl/mac_acc_adder.sv
// rtl/mac_acc_adder.sv - ACC_W-wide add with carry-out built from chained cla_8bit slices
module mac_acc_adder #(
    parameter int ACC_W = 16
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    localparam int NB = (ACC_W + 7) / 8;
    localparam int PW = NB * 8;

    logic [PW-1:0] a_pad;
    logic [PW-1:0] b_pad;
    logic [PW-1:0] s_pad;
    logic [NB:0]   c;
    logic [PW:0]   full;

    // Operands are zero-padded to whole slices, so bit ACC_W of the padded result is the carry
    assign a_pad = PW'(a);
    assign b_pad = PW'(b);
    assign c[0]  = 1'b0;

    for (genvar k = 0; k < NB; k++) begin : g_slice
        cla_8bit u_cla (
            .a    (a_pad[8*k +: 8]),
            .b    (b_pad[8*k +: 8]),
            .cin  (c[k]),
            .s    (s_pad[8*k +: 8]),
            .cout (c[k + 1])
        );
    end

    assign full  = {c[NB], s_pad};
    assign sum   = full[ACC_W-1:0];
    assign carry = full[ACC_W];

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - frame accumulator with valid/ready result register; MAC_ACC_SAT_EN selects saturation
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [ACC_W-1:0]   out_acc_q, out_acc_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;
    logic [ACC_W-1:0]   sum_val;
    logic [CNT_W-1:0]   cnt_inc;
    logic               ovf_inc;

    // Input is taken whenever the result register is empty or draining this cycle
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    mac_acc_adder #(
        .ACC_W (ACC_W)
    ) u_adder (
        .a     (acc_q),
        .b     ({{(ACC_W - PROD_W){1'b0}}, in_prod}),
        .sum   (add_sum),
        .carry (add_carry)
    );

`ifdef MAC_ACC_SAT_EN
    // Clamp on carry; a clamped accumulator re-clamps on any further nonzero term
    assign sum_val = add_carry ? {ACC_W{1'b1}} : add_sum;
`else
    assign sum_val = add_sum;
`endif

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    assign ovf_inc = ovf_q | add_carry;

    // Next-state: accumulate or close the frame into the result register
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q && !out_ready;
        out_acc_d   = out_acc_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if (in_last) begin
                        out_valid_d = 1'b1;
                        out_acc_d   = sum_val;
                        out_count_d = cnt_inc;
                        out_ovf_d   = ovf_inc;
                        acc_d       = '0;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        acc_d   = sum_val;
                        cnt_d   = cnt_inc;
                        ovf_d   = ovf_inc;
                        state_d = ACC;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // State registers; reset discards any frame in progress and the pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_acc_q   <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_acc_q   <= out_acc_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_acc   = out_acc_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - table-driven scoreboard bench for mac_accumulator
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_prod = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_acc;
    logic [7:0]  out_count;
    logic        out_ovf;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic [15:0] acc;
        logic [7:0]  cnt;
        logic        ovf;
    } exp_t;

    typedef struct {
        logic [7:0]  prod;
        logic        last;
        int          gap;
        logic [15:0] ea;
        logic [7:0]  ec;
        logic        eo;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[0:6];

    mac_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one beat, wait for acceptance, push the expected result when it closes a frame
    task automatic beat(input logic [7:0] p, input logic last, input int gap,
                        input logic [15:0] ea, input logic [7:0] ec, input logic eo);
        bit   ok;
        exp_t e;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_prod  = p;
        in_last  = last;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_fail++;
            $display("FAIL beat_timeout: in_ready stayed 0, expected 1");
        end
        @(posedge clk);
        #1;
        if (ok && last) begin
            e.acc = ea;
            e.cnt = ec;
            e.ovf = eo;
            sb.push_back(e);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Output monitor: each transfer must match the oldest pending expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {31'd0, out_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_acc", {16'd0, out_acc}, {16'd0, e.acc});
                chk("out_count", {24'd0, out_count}, {24'd0, e.cnt});
                chk("out_ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
            end
        end
    end

    initial begin
        logic [15:0] ovf_exp;

        tbl[0] = '{8'd225, 1'b0, 0, 16'd0,   8'd0, 1'b0};
        tbl[1] = '{8'd225, 1'b0, 0, 16'd0,   8'd0, 1'b0};
        tbl[2] = '{8'd225, 1'b0, 0, 16'd0,   8'd0, 1'b0};
        tbl[3] = '{8'd225, 1'b1, 2, 16'd900, 8'd4, 1'b0};
        tbl[4] = '{8'd100, 1'b0, 2, 16'd0,   8'd0, 1'b0};
        tbl[5] = '{8'd50,  1'b0, 1, 16'd0,   8'd0, 1'b0};
        tbl[6] = '{8'd25,  1'b1, 2, 16'd175, 8'd3, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_acc", {16'd0, out_acc}, 32'd0);
        chk("rst_out_count", {24'd0, out_count}, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-frame discards partial sum
        beat(8'd10, 1'b0, 0, 16'd0, 8'd0, 1'b0);
        beat(8'd20, 1'b0, 0, 16'd0, 8'd0, 1'b0);
        beat(8'd30, 1'b0, 0, 16'd0, 8'd0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        beat(8'd5, 1'b1, 0, 16'd5, 8'd1, 1'b0);
        @(negedge clk);
        chk("midrst_valid_after", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        // Table: basic frame and frame with gaps
        for (int i = 0; i < 7; i++) begin
            beat(tbl[i].prod, tbl[i].last, tbl[i].gap, tbl[i].ea, tbl[i].ec, tbl[i].eo);
        end

        // Back-to-back single-term frames keep out_valid high
        beat(8'd1, 1'b1, 0, 16'd1, 8'd1, 1'b0);
        chk("b2b_valid1", {31'd0, out_valid}, 32'd1);
        beat(8'd2, 1'b1, 0, 16'd2, 8'd1, 1'b0);
        chk("b2b_valid2", {31'd0, out_valid}, 32'd1);
        beat(8'd3, 1'b1, 0, 16'd3, 8'd1, 1'b0);
        chk("b2b_valid3", {31'd0, out_valid}, 32'd1);
        @(negedge clk);
        chk("b2b_acc3", {16'd0, out_acc}, 32'd3);
        @(negedge clk);
        chk("b2b_drained", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Backpressure stalls a following frame, including its first beat
        out_ready = 1'b0;
        beat(8'd3, 1'b1, 0, 16'd3, 8'd1, 1'b0);
        fork
            begin
                beat(8'd7, 1'b0, 0, 16'd0, 8'd0, 1'b0);
                beat(8'd8, 1'b1, 0, 16'd15, 8'd2, 1'b0);
            end
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("bp_hold_acc", {16'd0, out_acc}, 32'd3);
                    chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                out_ready = 1'b0;
            end
        join
        @(negedge clk);
        chk("bp_result_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_result_acc", {16'd0, out_acc}, 32'd15);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Overflow: 258 x 255 = 65790
`ifdef MAC_ACC_SAT_EN
        ovf_exp = 16'd65535;
`else
        ovf_exp = 16'd254;
`endif
        for (int i = 0; i < 258; i++) begin
            beat(8'd255, (i == 257), 0, ovf_exp, 8'd255, 1'b1);
        end

        repeat (20) @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        chk("final_out_valid", {31'd0, out_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Accumulate stage of the MAC datapath; sits directly downstream of the pipelined 4x4 Wallace multiplier and consumes its 8-bit unsigned product each cycle.
- Sums a frame of products, terminated by in_last, into an ACC_W-bit result.
- Presents the result through a one-entry valid/ready output register, with term count and overflow flag.
- Upstream valid tracking matches the multiplier's fixed 3-cycle latency; this block does not delay anything itself.

Parameters:
- PROD_W, 8, product width (unsigned input).
- ACC_W, 16, accumulator/result width; must be >= PROD_W + 1.
- CNT_W, 8, term-counter width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high; clears all state on the next rising edge.
- in_valid  input  1  in_prod/in_last valid this cycle.
- in_ready  output  1  block accepts a beat this cycle; combinational: !out_valid || out_ready.
- in_prod  input  PROD_W  unsigned product from multiplier.
- in_last  input  1  beat is the final term of the frame.
- out_valid  output  1  result register holds an unconsumed frame result.
- out_ready  input  1  consumer takes result this cycle.
- out_acc  output  ACC_W  frame sum.
- out_count  output  CNT_W  number of terms in the frame, saturating at 2^CNT_W-1.
- out_ovf  output  1  sticky: frame sum exceeded 2^ACC_W-1.

Behaviour:
- Accept = in_valid && in_ready.
- Transfer = out_valid && out_ready.
- Reset values (sync, rst=1 at edge):
  - acc=0, cnt=0, ovf=0, state=IDLE.
  - out_valid=0, out_acc=0, out_count=0, out_ovf=0.
  - rst dominates all other inputs; a frame in progress is discarded.
- Arithmetic: sum = acc + zero_extend(in_prod), computed ACC_W+1 wide; carry bit = overflow.
- Without the saturation option the accumulator wraps modulo 2^ACC_W.
- Counter: cnt_next = (cnt == all-ones) ? cnt : cnt + 1.
- FSM (state of the partial frame):
  - IDLE: acc=0, cnt=0, ovf=0.
    - Accept with !in_last -> ACC, with acc=sum, cnt=1, ovf=carry.
    - Accept with in_last -> single-term frame; result loaded, stay IDLE.
  - ACC: accept with !in_last -> acc=sum, cnt=cnt_next, ovf|=carry.
  - ACC: accept with in_last -> result loaded; acc, cnt and ovf cleared; -> IDLE.
- Result load (accept with in_last):
  - out_acc=sum, out_count=cnt_next (1 from IDLE), out_ovf=ovf|carry.
  - out_valid=1 on the following cycle.
  - Latency: last beat accepted at edge N -> out_valid high after edge N, observed in cycle N+1.
- Output register:
  - out_valid clears on transfer unless a new result loads on the same edge; in that case out_valid stays 1 and new data replaces the old.
  - out_acc, out_count and out_ovf hold stable while out_valid && !out_ready.
- Backpressure: while out_valid && !out_ready, in_ready=0 and acc/cnt freeze, including mid-frame.
- Cycles with in_valid=0 leave all state unchanged (gaps are allowed within a frame).
- No combinational path from in_valid or in_prod to any output; the only combinational output is in_ready, driven from out_ready.

Optional Feature:
- Macro MAC_ACC_SAT_EN.
- Defined: when the carry is set, acc and out_acc clamp to 2^ACC_W-1 and later terms keep the clamp. out_ovf behaves the same.
- Undefined: wrap modulo 2^ACC_W, with out_ovf flagging the wrap.

Decomposition:
- Package mac_pkg:
  - PROD_W/ACC_W/CNT_W defaults.
  - FSM state enum {IDLE, ACC}.
  - ACC_MAX constant (all-ones ACC_W).
- One sub-module: mac_acc_adder. It is an ACC_W-wide carry-lookahead add with carry-out, built by chaining cla_8bit instances (two for ACC_W=16), and is reusable by the later accumulator-clear path.

Test Plan:
- Reset mid-frame: feed 3 beats (prod 10,20,30, no last), assert rst one cycle, then frame {5, last} -> out_acc=5, out_count=1, out_ovf=0; no output before the reset.
- Basic frame: prods 225,225,225,225 (15x15) with last on the 4th, out_ready=1 -> out_valid one cycle after the last beat, out_acc=900, out_count=4, out_ovf=0.
- Backpressure: out_ready=0 after a frame of {3, last}. Then:
  - in_ready=0 and the next frame {7,8} stalls; out_acc stays 3.
  - After out_ready=1 for one cycle, the stalled frame completes with out_acc=15, out_count=2.
- Back-to-back single-term frames {1,last},{2,last},{3,last} on consecutive cycles with out_ready=1 -> out_acc sequence 1,2,3 with out_valid continuously high.
- Overflow with ACC_W=16: 258 beats of 255 (sum 65790) ->
  - out_ovf=1, out_count=255 (saturated).
  - Without MAC_ACC_SAT_EN: out_acc=254.
  - With MAC_ACC_SAT_EN: out_acc=65535.
- Gaps: frame {100, gap 2 cycles, 50, gap, 25 last} -> out_acc=175, out_count=3.
